score_disp_mux: RTL and testbench

Time-multiplexed scoreboard driver for the four-digit 7-segment display. Latches the two player scores and the winner flag from the game logic, then scans the digits in turn. For each digit it drives a 3-bit symbol code (0–3 = digit, 4 = "P", 5 = "-") into the downstream code-to-segment converter and drives the matching active-low anode. A winning player's digit blinks.

---
 rtl/disp_pkg.sv | 43 ++++
 rtl/tick_gen.sv | 22 ++
 rtl/score_disp_mux.sv | 83 ++++++++
 tb/tb_score_disp_mux.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the scoreboard display path: symbol codes, digit
// positions, the winner encoding and the latched score payload.
package disp_pkg;

  localparam logic [2:0] CODE_P     = 3'b100;
  localparam logic [2:0] CODE_MINUS = 3'b101;

  localparam logic [1:0] POS_R     = 2'd0;
  localparam logic [1:0] POS_MINUS = 2'd1;
  localparam logic [1:0] POS_L     = 2'd2;
  localparam logic [1:0] POS_P     = 2'd3;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_L    = 2'b01,
    WIN_R    = 2'b10
  } win_e;

  typedef struct packed {
    logic [1:0] sc_l;
    logic [1:0] sc_r;
    win_e       win;
  } score_t;

  // Raw 2'b11 from the game logic carries no winner.
  function automatic win_e decode_win(input logic [1:0] w);
    case (w)
      2'b01:   return WIN_L;
      2'b10:   return WIN_R;
      default: return WIN_NONE;
    endcase
  endfunction

  function automatic logic [2:0] sym_code(input logic [1:0] pos, input score_t s);
    case (pos)
      POS_P:     return CODE_P;
      POS_L:     return {1'b0, s.sc_l};
      POS_MINUS: return CODE_MINUS;
      default:   return {1'b0, s.sc_r};
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module tick_gen #(
  parameter int unsigned DIV = 100_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/score_disp_mux.sv
// Four-digit scoreboard scanner: latches scores/winner, walks the digits one
// slot per tick, and blinks the winning player's digit.
module score_disp_mux
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] score_l,
  input  logic [1:0] score_r,
  input  logic [1:0] winner,
  input  logic       score_valid,
  output logic [2:0] point,
  output logic [3:0] an
);

  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic          tick;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  score_t        lat;

  logic [1:0]    idx_nxt;
  logic          blank_c;
  logic [2:0]    point_nxt;
  logic [3:0]    an_nxt;

  tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next slot's symbol and anode pattern, taken from the pre-edge latch.
  always_comb begin
    idx_nxt   = idx + 2'd1;
    point_nxt = sym_code(idx_nxt, lat);
    blank_c   = !blink_on &&
                (((lat.win == WIN_L) && (idx_nxt == POS_L)) ||
                 ((lat.win == WIN_R) && (idx_nxt == POS_R)));
    an_nxt    = blank_c ? 4'b1111 : ~(4'b0001 << idx_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= 2'd0;
      point <= 3'b000;
      an    <= 4'b1110;
    end else if (tick) begin
      idx   <= idx_nxt;
      point <= point_nxt;
      an    <= an_nxt;
    end
  end

  // Blink phase runs on slot ticks regardless of the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat <= '{sc_l: 2'd0, sc_r: 2'd0, win: WIN_NONE};
    end else if (score_valid) begin
      lat <= '{sc_l: score_l, sc_r: score_r, win: decode_win(winner)};
    end
  end

endmodule

// File: tb/tb_score_disp_mux.sv
// Scoreboard bench: a tick-level reference model predicts each slot's
// display; a negedge monitor compares slot updates and holds between them.
module tb_score_disp_mux;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BLINK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] score_l = '0;
  logic [1:0] score_r = '0;
  logic [1:0] winner = '0;
  logic       score_valid = 1'b0;
  logic [2:0] point;
  logic [3:0] an;

  score_disp_mux #(.REFRESH_DIV(DIV), .BLINK_TICKS(BLINK)) dut (
    .clk         (clk),
    .rst         (rst),
    .score_l     (score_l),
    .score_r     (score_r),
    .winner      (winner),
    .score_valid (score_valid),
    .point       (point),
    .an          (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] an;
    logic [2:0] pt;
  } exp_t;

  exp_t       q[$];
  int         gcyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] hold_an = 4'b1110;
  logic [2:0] hold_pt = 3'b000;

  // Reference model state
  int         cyc = 0;
  int         m_l = 0, m_r = 0, m_w = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Monitor: adopt the slot due on this edge, then compare against it.
  always @(negedge clk) begin
    string tag;
    tag = "hold";
    if (q.size() > 0 && q[0].due < gcyc) begin
      checks++;
      errors++;
      $display("FAIL missed_slot due=%0d now=%0d", q[0].due, gcyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == gcyc) begin
      exp_t e;
      e = q.pop_front();
      hold_an = e.an;
      hold_pt = e.pt;
      tag = "slot";
    end
    checks++;
    if (an !== hold_an || point !== hold_pt) begin
      errors++;
      $display("FAIL %s cyc=%0d an=%b point=%b expected an=%b point=%b",
               tag, gcyc, an, point, hold_an, hold_pt);
    end
  end

  // Expected display after the k-th slot tick since reset.
  function automatic exp_t predict(input int k, input int l, input int r, input int w);
    exp_t e;
    int   pos;
    bit   visible;
    pos     = k % 4;
    visible = (((k - 1) / BLINK) % 2) == 0;
    case (pos)
      3: e.pt = 3'd4;
      2: e.pt = 3'(l);
      1: e.pt = 3'd5;
      default: e.pt = 3'(r);
    endcase
    if (!visible && ((w == 1 && pos == 2) || (w == 2 && pos == 0))) e.an = 4'b1111;
    else                                                            e.an = 4'b1111 & ~(4'b0001 << pos);
    e.due = 0;
    return e;
  endfunction

  // Called just after an edge: sets inputs for the next edge and predicts it.
  task automatic step(input bit sv, input int l, input int r, input int w);
    int   nxt;
    exp_t e;
    nxt = cyc + 1;
    if (nxt % DIV == 0) begin
      e     = predict(nxt / DIV, m_l, m_r, m_w);
      e.due = gcyc + 1;
      q.push_back(e);
    end
    if (sv) begin
      m_l = l; m_r = r; m_w = (w == 1 || w == 2) ? w : 0;
    end
    score_valid = sv;
    score_l     = 2'(l);
    score_r     = 2'(r);
    winner      = 2'(w);
    cyc         = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
  endtask

  task automatic do_reset();
    score_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    hold_an = 4'b1110;
    hold_pt = 3'b000;
    m_l = 0; m_r = 0; m_w = 0;
    #1;
    checks++;
    if (an !== 4'b1110 || point !== 3'b000) begin
      errors++;
      $display("FAIL async_reset an=%b point=%b expected an=1110 point=000", an, point);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at gcyc=%0d", gcyc);
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    do_reset();
    idle(20);

    // Score strobe away from a tick
    while ((cyc + 1) % DIV == 0) idle(1);
    step(1'b1, 2, 3, 0);
    idle(16);

    // Score strobe coinciding with a tick edge
    while ((cyc + 1) % DIV != 0) idle(1);
    step(1'b1, 1, 0, 0);
    idle(16);

    step(1'b1, 3, 1, 1);
    idle(48);
    step(1'b1, 2, 2, 3);
    idle(48);
    step(1'b1, 0, 2, 2);
    idle(48);
    step(1'b1, 1, 3, 0);
    idle(8);

    // Reset mid-slot while index 2 is displayed
    step(1'b1, 3, 2, 1);
    while (!(((cyc / DIV) % 4) == 2 && (cyc % DIV) == 1)) idle(1);
    do_reset();
    idle(20);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 7) == 0) begin
        step(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
      end else begin
        step(1'b0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
      end
    end

    while ((cyc % DIV) != 0) idle(1);
    idle(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
